// File: rtl/fetch_buffer.sv
// fetch_buffer: FIFO decoupling fetch from decode, with show-ahead head, flush and bubble output
module fetch_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] InstrF,
    input  logic [DATA_W-1:0] PCPlus4F,
    input  logic              ValidF,
    output logic              ReadyF,
    output logic [DATA_W-1:0] InstrD,
    output logic [DATA_W-1:0] PCPlus4D,
    output logic              ValidD,
    input  logic              StallD,
    input  logic              FlushD,
    output logic [CNT_W-1:0]  Count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [DATA_W-1:0] pc_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic              push, pop;

    assign ReadyF   = Count != CNT_W'(DEPTH);
    assign ValidD   = Count != '0;
    assign push     = ValidF & ReadyF & ~FlushD;
    assign pop      = ValidD & ~StallD & ~FlushD;
    assign InstrD   = ValidD ? instr_mem[rd_ptr] : '0;
    assign PCPlus4D = ValidD ? pc_mem[rd_ptr] : '0;

    // storage is never cleared; empty outputs are masked instead
    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            instr_mem[wr_ptr] <= InstrF;
            pc_mem[wr_ptr]    <= PCPlus4F;
        end
    end

    // pointers and occupancy; reset and flush both empty the buffer
    always_ff @(posedge CLK) begin
        if (RST || FlushD) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            Count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            Count <= (push && !pop) ? Count + CNT_W'(1) : (pop && !push) ? Count - CNT_W'(1) : Count;
        end
    end
endmodule
